// File: rtl/sprite_palette_lut_if.sv
// ---------------------------------------------------------------------------
// sprite_palette_lut_if
//
// Purpose:
//   Bundles the pixel lookup stream, the palette write port, the flash-effect
//   controls and the colour result of sprite_palette_lut into one interface.
//   The clock and reset stay outside as plain module ports.
//
// Parameters:
//   IDX_W      palette index width
//   CH_W       bits per colour channel
//   NUM_BANKS  number of palette banks; BW = max(1, clog2(NUM_BANKS))
//
// Signals (direction seen from the master, i.e. the pixel/host side):
//   pix_valid   out  index/bank_sel valid this cycle
//   index       out  palette index
//   bank_sel    out  bank used for the lookup
//   wr_en       out  palette write strobe
//   wr_bank     out  bank written
//   wr_addr     out  entry written
//   wr_data     out  {R,G,B} entry data
//   frame_tick  out  one-cycle pulse per frame
//   flash_en    out  enable flash/dim effect
//   out_valid   in   colour/transparent valid
//   red         in   red channel
//   green       in   green channel
//   blue        in   blue channel
//   transparent in   pixel is the transparent key
// ---------------------------------------------------------------------------
interface sprite_palette_lut_if #(
  parameter int IDX_W     = 4,
  parameter int CH_W      = 4,
  parameter int NUM_BANKS = 2
);

  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic              pix_valid;
  logic [IDX_W-1:0]  index;
  logic [BW-1:0]     bank_sel;
  logic              wr_en;
  logic [BW-1:0]     wr_bank;
  logic [IDX_W-1:0]  wr_addr;
  logic [3*CH_W-1:0] wr_data;
  logic              frame_tick;
  logic              flash_en;
  logic              out_valid;
  logic [CH_W-1:0]   red;
  logic [CH_W-1:0]   green;
  logic [CH_W-1:0]   blue;
  logic              transparent;

  // Pixel/host side: drives lookups, writes and effect controls.
  modport master (
    output pix_valid, index, bank_sel,
    output wr_en, wr_bank, wr_addr, wr_data,
    output frame_tick, flash_en,
    input  out_valid, red, green, blue, transparent
  );

  // Palette side: the lookup block itself.
  modport slave (
    input  pix_valid, index, bank_sel,
    input  wr_en, wr_bank, wr_addr, wr_data,
    input  frame_tick, flash_en,
    output out_valid, red, green, blue, transparent
  );

endinterface

// File: rtl/sprite_palette_lut.sv
// ---------------------------------------------------------------------------
// sprite_palette_lut
//
// Purpose:
//   Run-time programmable, multi-bank sprite palette. Each valid pixel index
//   is translated to an RGB colour through a two-stage pipeline (palette read,
//   then effect/transparency). A frame-synchronous flash controller can halve
//   every colour channel on alternating groups of frames.
//
// Parameters:
//   IDX_W        palette index width (2**IDX_W entries per bank)
//   CH_W         bits per colour channel
//   NUM_BANKS    number of palette banks (>= 1)
//   TRANSP_IDX   index value treated as the transparent key
//   FLASH_FRAMES frames per flash half-period (>= 1)
//
// Ports:
//   Clk      in  system clock, rising edge
//   Reset_n  in  asynchronous active-low reset
//   bus      slave modport of sprite_palette_lut_if (lookup stream, write
//                port, flash controls and colour result)
// ---------------------------------------------------------------------------
module sprite_palette_lut #(
  parameter int IDX_W        = 4,
  parameter int CH_W         = 4,
  parameter int NUM_BANKS    = 2,
  parameter int TRANSP_IDX   = 0,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  sprite_palette_lut_if.slave  bus
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int BW      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int DW      = 3 * CH_W;
  localparam int FW      = $clog2(FLASH_FRAMES + 1);

  typedef enum logic {
    S_NORMAL = 1'b0,
    S_DIM    = 1'b1
  } flash_state_t;

  // Palette storage
  logic [DW-1:0]    r_mem [NUM_BANKS][ENTRIES];

  // Stage 1 registers
  logic             r_v1;
  logic [DW-1:0]    r_c1;
  logic             r_t1;

  // Stage 2 / output registers
  logic             r_outValid;
  logic             r_transparent;
  logic [DW-1:0]    r_colour;

  // Flash controller
  flash_state_t     r_state;
  logic [FW-1:0]    r_fcnt;

  // Combinational helpers
  logic [DW-1:0]    w_rdColour;
  logic             w_isTransp;
  logic             w_dimPhase;
  logic [DW-1:0]    w_s2Colour;

  // Palette write port. Banks are matched explicitly against each legal bank
  // number, so a wr_bank beyond NUM_BANKS simply matches nothing and the
  // write is dropped instead of aliasing into another bank.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          r_mem[b][e] <= '0;
        end
      end
    end else if (bus.wr_en) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bus.wr_bank == BW'(b)) begin
          r_mem[b][bus.wr_addr] <= bus.wr_data;
        end
      end
    end
  end

  // Palette read mux. Reads the registered array, so a write on the same
  // edge is not visible yet (read-before-write). An out-of-range bank reads
  // as black; the transparency flag depends on the index alone.
  always_comb begin
    w_rdColour = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bus.bank_sel == BW'(b)) begin
        w_rdColour = r_mem[b][bus.index];
      end
    end
  end

  assign w_isTransp = (bus.index == IDX_W'(TRANSP_IDX));

  // Stage 1: capture the raw palette colour and the transparency flag.
  // Data registers only load on a valid pixel; downstream ignores them
  // otherwise.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_v1 <= 1'b0;
      r_c1 <= '0;
      r_t1 <= 1'b0;
    end else begin
      r_v1 <= bus.pix_valid;
      if (bus.pix_valid) begin
        r_c1 <= w_rdColour;
        r_t1 <= w_isTransp;
      end
    end
  end

  // Flash controller. Disabling the effect returns to NORMAL and rewinds the
  // frame count immediately, so re-enabling always starts a fresh
  // half-period.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_NORMAL;
      r_fcnt  <= '0;
    end else if (!bus.flash_en) begin
      r_state <= S_NORMAL;
      r_fcnt  <= '0;
    end else if (bus.frame_tick) begin
      if (r_fcnt == FW'(FLASH_FRAMES - 1)) begin
        r_fcnt <= '0;
        case (r_state)
          S_NORMAL: r_state <= S_DIM;
          S_DIM:    r_state <= S_NORMAL;
          default:  r_state <= S_NORMAL;
        endcase
      end else begin
        r_fcnt <= r_fcnt + FW'(1);
      end
    end
  end

  assign w_dimPhase = (r_state == S_DIM);

  // Stage 2 colour: transparent pixels are forced black, otherwise each
  // channel is halved independently while dimmed.
  always_comb begin
    w_s2Colour = r_c1;
    if (r_t1) begin
      w_s2Colour = '0;
    end else if (w_dimPhase) begin
      for (int ch = 0; ch < 3; ch++) begin
        w_s2Colour[ch*CH_W +: CH_W] = r_c1[ch*CH_W +: CH_W] >> 1;
      end
    end
  end

  // Stage 2 registers. Colour and transparent hold across invalid cycles.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_outValid    <= 1'b0;
      r_transparent <= 1'b0;
      r_colour      <= '0;
    end else begin
      r_outValid <= r_v1;
      if (r_v1) begin
        r_transparent <= r_t1;
        r_colour      <= w_s2Colour;
      end
    end
  end

  assign bus.out_valid   = r_outValid;
  assign bus.transparent = r_transparent;
  assign bus.red         = r_colour[3*CH_W-1 -: CH_W];
  assign bus.green       = r_colour[2*CH_W-1 -: CH_W];
  assign bus.blue        = r_colour[CH_W-1 -: CH_W];

endmodule

// File: tb/tb_sprite_palette_lut.sv
// ---------------------------------------------------------------------------
// tb_sprite_palette_lut
//
// Directed bench for sprite_palette_lut with 3 banks (so an out-of-range
// bank number exists) and FLASH_FRAMES=2. Inputs change 1 time unit after
// a rising edge; outputs are observed at the same point, so each step()
// shows the effect of exactly one edge. The observed word is
// {out_valid, transparent, R, G, B}.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sprite_palette_lut;

  localparam int IDX_W = 4;
  localparam int CH_W  = 4;
  localparam int NB    = 3;
  localparam int FF    = 2;

  logic Clk;
  logic Reset_n;
  int   checks;
  int   errors;
  logic [13:0] obs;
  logic [13:0] exp;

  sprite_palette_lut_if #(.IDX_W(IDX_W), .CH_W(CH_W), .NUM_BANKS(NB)) bus ();

  sprite_palette_lut #(
    .IDX_W(IDX_W), .CH_W(CH_W), .NUM_BANKS(NB),
    .TRANSP_IDX(0), .FLASH_FRAMES(FF)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [13:0] obsVec();
    return {bus.out_valid, bus.transparent, bus.red, bus.green, bus.blue};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic setPix(input logic v, input logic [1:0] bank, input logic [3:0] idx);
    bus.pix_valid = v;
    bus.bank_sel  = bank;
    bus.index     = idx;
  endtask

  task automatic writeEntry(input logic [1:0] bank, input logic [3:0] addr, input logic [11:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_bank = bank;
    bus.wr_addr = addr;
    bus.wr_data = data;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    setPix(1'b0, 2'd0, 4'd0);
    bus.wr_en = 1'b0; bus.wr_bank = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.frame_tick = 1'b0; bus.flash_en = 1'b0;
    #2;
    exp = 14'h0; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL reset_state: got %h expected %h", obs, exp); end
    step(); step();
    @(negedge Clk); Reset_n = 1'b1;
    step();
    setPix(1'b1, 2'd0, 4'd5);
    step();
    setPix(1'b0, 2'd0, 4'd0);
    exp = 14'h0; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL reset_latency1: got %h expected %h", obs, exp); end
    step();
    exp = {2'b10, 12'h000}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL reset_lookup: got %h expected %h", obs, exp); end
    step();
  endtask

  task automatic test_program_stream();
    writeEntry(2'd0, 4'd3, 12'hA5C);
    writeEntry(2'd1, 4'd3, 12'h123);
    setPix(1'b1, 2'd0, 4'd3); step();
    setPix(1'b1, 2'd1, 4'd3); step();
    exp = {2'b10, 12'hA5C}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL stream_p1: got %h expected %h", obs, exp); end
    setPix(1'b1, 2'd0, 4'd3); step();
    exp = {2'b10, 12'h123}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL stream_p2: got %h expected %h", obs, exp); end
    setPix(1'b0, 2'd0, 4'd0); step();
    exp = {2'b10, 12'hA5C}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL stream_p3: got %h expected %h", obs, exp); end
    step();
    exp = {2'b00, 12'hA5C}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL stream_hold: got %h expected %h", obs, exp); end
  endtask

  task automatic test_transparency();
    writeEntry(2'd0, 4'd0, 12'hFFF);
    writeEntry(2'd0, 4'd1, 12'h3B7);
    setPix(1'b1, 2'd0, 4'd0); step();
    setPix(1'b1, 2'd0, 4'd1); step();
    exp = {2'b11, 12'h000}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL transp_key: got %h expected %h", obs, exp); end
    setPix(1'b0, 2'd0, 4'd0); step();
    exp = {2'b10, 12'h3B7}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL transp_opaque: got %h expected %h", obs, exp); end
    step();
  endtask

  task automatic test_collision();
    writeEntry(2'd0, 4'd7, 12'h111);
    bus.wr_en = 1'b1; bus.wr_bank = 2'd0; bus.wr_addr = 4'd7; bus.wr_data = 12'h999;
    setPix(1'b1, 2'd0, 4'd7);
    step();
    bus.wr_en = 1'b0;
    step();
    exp = {2'b10, 12'h111}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL collide_old: got %h expected %h", obs, exp); end
    setPix(1'b0, 2'd0, 4'd0); step();
    exp = {2'b10, 12'h999}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL collide_new: got %h expected %h", obs, exp); end
    step();
  endtask

  task automatic test_bank_range();
    writeEntry(2'd3, 4'd4, 12'hFFF);
    writeEntry(2'd2, 4'd4, 12'h2C6);
    setPix(1'b1, 2'd3, 4'd4); step();
    setPix(1'b1, 2'd2, 4'd4); step();
    exp = {2'b10, 12'h000}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL bank_oor_read: got %h expected %h", obs, exp); end
    setPix(1'b1, 2'd3, 4'd0); step();
    exp = {2'b10, 12'h2C6}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL bank_last: got %h expected %h", obs, exp); end
    setPix(1'b1, 2'd0, 4'd4); step();
    exp = {2'b11, 12'h000}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL bank_oor_transp: got %h expected %h", obs, exp); end
    setPix(1'b1, 2'd1, 4'd4); step();
    exp = {2'b10, 12'h000}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL bank_no_alias0: got %h expected %h", obs, exp); end
    setPix(1'b0, 2'd0, 4'd0); step();
    exp = {2'b10, 12'h000}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL bank_no_alias1: got %h expected %h", obs, exp); end
    step();
  endtask

  task automatic test_flash();
    writeEntry(2'd0, 4'd2, 12'hEC8);
    bus.flash_en = 1'b1;
    setPix(1'b1, 2'd0, 4'd2);
    step(); step();
    exp = {2'b10, 12'hEC8}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL flash_normal: got %h expected %h", obs, exp); end
    tick(); step();
    exp = {2'b10, 12'hEC8}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL flash_one_tick: got %h expected %h", obs, exp); end
    tick();
    exp = {2'b10, 12'hEC8}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL flash_toggle_edge: got %h expected %h", obs, exp); end
    step();
    exp = {2'b10, 12'h764}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL flash_dim: got %h expected %h", obs, exp); end
    tick(); step(); tick();
    exp = {2'b10, 12'h764}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL flash_dim_hold: got %h expected %h", obs, exp); end
    step();
    exp = {2'b10, 12'hEC8}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL flash_back: got %h expected %h", obs, exp); end
    tick(); tick(); step();
    exp = {2'b10, 12'h764}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL flash_dim2: got %h expected %h", obs, exp); end
    // Transparent key stays black while dimmed
    setPix(1'b1, 2'd0, 4'd0); step();
    setPix(1'b1, 2'd0, 4'd2); step();
    exp = {2'b11, 12'h000}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL flash_transp: got %h expected %h", obs, exp); end
    // Leave fcnt at 1, then drop the enable while dimmed
    tick();
    bus.flash_en = 1'b0;
    step();
    exp = {2'b10, 12'h764}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL flash_drop_edge: got %h expected %h", obs, exp); end
    step();
    exp = {2'b10, 12'hEC8}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL flash_drop_normal: got %h expected %h", obs, exp); end
    // A single tick after re-enable must not toggle if the count was cleared
    bus.flash_en = 1'b1;
    tick(); step();
    exp = {2'b10, 12'hEC8}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL flash_fcnt_cleared: got %h expected %h", obs, exp); end
    // Ticks are ignored while disabled
    bus.flash_en = 1'b0;
    tick(); tick(); tick(); step();
    exp = {2'b10, 12'hEC8}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL flash_disabled_ticks: got %h expected %h", obs, exp); end
    setPix(1'b0, 2'd0, 4'd0);
    step(); step();
  endtask

  task automatic test_async_reset();
    writeEntry(2'd1, 4'd9, 12'h5A5);
    setPix(1'b1, 2'd1, 4'd9);
    step(); step();
    exp = {2'b10, 12'h5A5}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL areset_pre: got %h expected %h", obs, exp); end
    #2;
    Reset_n = 1'b0;
    #1;
    exp = 14'h0; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL areset_immediate: got %h expected %h", obs, exp); end
    setPix(1'b0, 2'd0, 4'd0);
    step();
    @(negedge Clk); Reset_n = 1'b1;
    step();
    setPix(1'b1, 2'd1, 4'd9); step();
    exp = 14'h0; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL areset_latency1: got %h expected %h", obs, exp); end
    setPix(1'b1, 2'd0, 4'd3); step();
    exp = {2'b10, 12'h000}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL areset_cleared1: got %h expected %h", obs, exp); end
    setPix(1'b0, 2'd0, 4'd0); step();
    exp = {2'b10, 12'h000}; obs = obsVec(); checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL areset_cleared0: got %h expected %h", obs, exp); end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_program_stream();
    test_transparency();
    test_collision();
    test_bank_range();
    test_flash();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_palette_lut.md
# sprite_palette_lut

Programmable, multi-bank sprite colour lookup. It maps a per-pixel palette index to RGB through a 2-stage pipeline, flags a transparent key index and applies an optional frame-synchronous flash/dim effect (e.g. low-battery blink). It sits between the sprite ROM address/index fetch and the VGA colour mux. The host or game logic rewrites palette entries at run time, so hard-coded per-sprite palette modules are no longer needed.

## Interface
- IDX_W, 4, palette index width; 2**IDX_W entries per bank
- CH_W, 4, bits per colour channel
- NUM_BANKS, 2, number of palette banks (≥1); bank select width BW = max(1, clog2(NUM_BANKS))
- TRANSP_IDX, 0, index value treated as transparent
- FLASH_FRAMES, 8, frames per flash half-period (≥1)

Ports:
- Clk  in  1  system clock, all logic rising-edge
- Reset_n  in  1  asynchronous, active-low reset
- pix_valid  in  1  index/bank_sel valid this cycle
- index  in  IDX_W  palette index
- bank_sel  in  BW  bank used for the lookup
- wr_en  in  1  palette write strobe
- wr_bank  in  BW  bank written
- wr_addr  in  IDX_W  entry written
- wr_data  in  3*CH_W  {R,G,B} entry data
- frame_tick  in  1  one-cycle pulse per frame (vsync edge)
- flash_en  in  1  enable flash effect
- out_valid  out  1  red/green/blue/transparent valid
- red, green, blue  out  CH_W each  output colour
- transparent  out  1  pixel is transparent key

## Operation
- Storage: NUM_BANKS × 2**IDX_W × 3*CH_W flops. Reset clears every entry to 0.
- Write: when wr_en=1, mem[wr_bank][wr_addr] ← wr_data at the clock edge. wr_bank ≥ NUM_BANKS is ignored (no write). Writes are independent of pix_valid.
- Lookup stage 1 (S1): register v1=pix_valid, c1=mem[bank_sel][index] using pre-write contents (read-before-write), and t1=(index==TRANSP_IDX). bank_sel ≥ NUM_BANKS reads as colour 0 with t1 unaffected.
- Stage 2 (S2): out_valid←v1 and transparent←t1. Colour ← 0 if t1. Otherwise colour ← c1>>1 per channel if dim_phase=1, else c1.
- When out_valid=0, colour/transparent hold their previous values and must not be consumed.
- Flash controller, two states NORMAL(dim_phase=0)/DIM(dim_phase=1):
  - frame counter fcnt, width clog2(FLASH_FRAMES+1)
  - flash_en=0: fcnt←0, state←NORMAL, synchronously every cycle
  - flash_en=1 and frame_tick=1: if fcnt==FLASH_FRAMES-1 then fcnt←0 and the state toggles; else fcnt←fcnt+1
- dim_phase is sampled in S2, so an effect change applies to whatever pixel is in S2 that cycle (no mid-pixel tearing concerns; changes only at frame_tick).

## Timing
- Reset values: out_valid=0, red=green=blue=0, transparent=0, fcnt=0, state NORMAL, all palette entries 0.
- Lookup latency is 2 cycles: index at edge N gives the result on outputs after edge N+2. Full throughput is 1 pixel/cycle, with no stalls and no backpressure.
- Write→read visibility: a write at edge N is seen by a lookup sampled at edge N+1 or later. A same-edge lookup sees old data.
- Toggle: with flash_en high, the state toggles on the FLASH_FRAMES-th frame_tick, and dim_phase is visible to S2 on the following cycle.
- Reset asserted mid-stream clears the pipeline and palette immediately (async). The first valid output appears 2 cycles after the first pix_valid following deassertion.

## Test plan
- Reset then lookup: assert Reset_n=0, release. Send pix_valid=1, bank 0, index 5 → after 2 cycles out_valid=1, RGB=0,0,0, transparent=0.
- Program and stream: write bank0[3]=12'hA5C and bank1[3]=12'h123. Stream index 3 with bank_sel 0,1,0 on consecutive cycles → outputs A/5/C, 1/2/3, A/5/C on 3 consecutive cycles, 2-cycle latency.
- Transparency: write bank0[0]=12'hFFF, look up index 0 → transparent=1, RGB=0. Index 1 → transparent=0.
- Read-before-write collision: bank0[7]=12'h111. At the same edge, write bank0[7]=12'h999 and look up index 7 → 1/1/1. Look up again next cycle → 9/9/9.
- Flash with FLASH_FRAMES=2: bank0[2]=12'hEC8, flash_en=1. Hold index 2; give 2 frame_ticks → output E/C/8 becomes 7/6/4. 2 more ticks → back to E/C/8. Drop flash_en while dim → next pixels E/C/8, fcnt=0.
- Async reset mid-stream: stream valid pixels, pull Reset_n low between edges → out_valid=0 and RGB=0 without a clock edge. After release, earlier-written entries read 0.
